// File: rtl/cdc_req_ack_tx.sv
// -----------------------------------------------------------------------------
// cdc_req_ack_tx
//
// Source-side controller for a 4-phase req/ack clock-domain-crossing handshake.
// A word is taken from a local valid/ready producer, parked on o_data and
// announced to the destination domain by raising o_req. The returning
// acknowledge is brought into i_clk through a SYNC_STAGES-deep flop chain and
// the controller walks the full protocol:
//   req up -> ack up -> req down -> ack down -> o_done
// o_data only changes on an accept, so it is stable for the whole time o_req
// is high and the destination may register it once it sees o_req rise.
//
// Parameters
//   DATA_W       width of the transferred word
//   SYNC_STAGES  depth of the i_ack synchronizer (2..4; clamped to that range)
//   TIMEOUT      wait-state cycles before o_err sets (0 disables the timeout)
//
// Ports (single clock domain i_clk, synchronous active-low reset i_rst_n)
//   i_clk      in   source-domain clock
//   i_rst_n    in   synchronous active-low reset
//   i_valid    in   producer has a word on i_data
//   i_data     in   word to transfer
//   o_ready    out  word accepted this cycle when i_valid is also high
//   o_req      out  registered request to the destination domain
//   o_data     out  registered captured word
//   i_ack      in   acknowledge from the destination domain (asynchronous)
//   o_done     out  one-cycle pulse in the first IDLE cycle after a transfer
//   o_busy     out  a transfer is in progress
//   o_err      out  sticky timeout flag
//   i_err_clr  in   clears o_err (a simultaneous set wins)
// -----------------------------------------------------------------------------
module cdc_req_ack_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_req,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ack,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_err,
    input  logic              i_err_clr
);

    // Out-of-range depths are pulled back into the legal 2..4 window so the
    // chain never degenerates into a single (metastability-unsafe) flop.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 :
                            ((SYNC_STAGES > 4) ? 4 : SYNC_STAGES);

    // Counter is wide enough to hold TIMEOUT itself (it saturates there).
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    // The flag is raised on the same edge the counter steps onto TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1)
                                                          : {CNT_W{1'b0}};
    localparam bit               TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [SYNC_N-1:0]   sync_r;
    logic                ack_s;
    logic                ready_s;
    logic                busy_s;
    logic                accept_s;
    logic                req_nxt_s;
    logic                done_nxt_s;
    logic [CNT_W-1:0]    wait_r;
    logic [CNT_W-1:0]    wait_nxt_s;
    logic                err_set_s;

    // Acknowledge synchronizer: i_ack enters at bit 0, ack_s is the last flop.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_r <= {SYNC_N{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_N-2:0], i_ack};
        end
    end

    assign ack_s = sync_r[SYNC_N-1];

    // A still-high acknowledge from the previous round (or a stale one after
    // reset) blocks new accepts until the destination has released it.
    assign busy_s   = (state_r != ST_IDLE);
    assign ready_s  = (state_r == ST_IDLE) && !ack_s;
    assign accept_s = i_valid && ready_s;

    assign o_ready  = ready_s;
    assign o_busy   = busy_s;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, next-request and completion-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = 1'b0;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    req_nxt_s   = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    req_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_nxt_s   = 1'b0;
                    state_nxt_s = ST_REL;
                end else begin
                    req_nxt_s   = 1'b1;
                    state_nxt_s = ST_REQ;
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    done_nxt_s  = 1'b0;
                    state_nxt_s = ST_REL;
                end
            end
            default: begin
                req_nxt_s   = 1'b0;
                done_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Wait counter: restarts on every state change, counts wait-state cycles
    // and parks at TIMEOUT. The error is a one-shot event on reaching TIMEOUT
    // so a clear issued during a long stall is not immediately overridden.
    always_comb begin
        wait_nxt_s = wait_r;
        err_set_s  = 1'b0;
        if (state_nxt_s != state_r) begin
            wait_nxt_s = CNT_ZERO;
        end else if ((state_r == ST_REQ) || (state_r == ST_REL)) begin
            if (wait_r != CNT_MAX) begin
                wait_nxt_s = wait_r + CNT_ONE;
            end else begin
                wait_nxt_s = wait_r;
            end
            if (TO_EN && (wait_r == CNT_LAST)) begin
                err_set_s = 1'b1;
            end else begin
                err_set_s = 1'b0;
            end
        end else begin
            wait_nxt_s = CNT_ZERO;
        end
    end

    // Wait counter register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wait_r <= CNT_ZERO;
        end else begin
            wait_r <= wait_nxt_s;
        end
    end

    // Registered handshake outputs; o_data loads only on an accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_req  <= 1'b0;
            o_done <= 1'b0;
            o_data <= {DATA_W{1'b0}};
        end else begin
            o_req  <= req_nxt_s;
            o_done <= done_nxt_s;
            if (accept_s) begin
                o_data <= i_data;
            end else begin
                o_data <= o_data;
            end
        end
    end

    // Sticky error flag; a set in the same cycle as a clear takes priority.
    // The FSM never aborts on timeout: dropping out of a half-finished 4-phase
    // exchange would leave the destination out of step.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_err <= 1'b0;
        end else if (err_set_s) begin
            o_err <= 1'b1;
        end else if (i_err_clr) begin
            o_err <= 1'b0;
        end else begin
            o_err <= o_err;
        end
    end

endmodule

// File: tb/tb_cdc_req_ack_tx.sv
// -----------------------------------------------------------------------------
// tb_cdc_req_ack_tx
//
// Two instances: dut index 0 uses SYNC_STAGES=2, index 1 uses SYNC_STAGES=3,
// both with TIMEOUT=10. Stimulus pushes the expected word and transfer length
// into a per-instance queue at accept time; a monitor pops and compares on
// every o_done pulse. Transfer length is counted from the accept edge to the
// o_done edge inclusive: 2*SYNC_STAGES + 3 + up_delay + down_delay, where the
// delays are the extra negedges the acknowledge model waits before toggling.
// -----------------------------------------------------------------------------
module tb_cdc_req_ack_tx;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Edge counter: at a negedge it holds the index of the latest rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    logic       vld      [2];
    logic [7:0] din      [2];
    logic       clr      [2];
    logic       ack_man  [2];
    logic       ack_auto [2];
    logic       auto_on  [2];
    int         up_dly   [2];
    int         dn_dly   [2];
    logic       ack      [2];
    logic       rdy      [2];
    logic       req      [2];
    logic       done     [2];
    logic       busy     [2];
    logic       err      [2];
    logic [7:0] dout     [2];

    assign ack[0] = auto_on[0] ? ack_auto[0] : ack_man[0];
    assign ack[1] = auto_on[1] ? ack_auto[1] : ack_man[1];

    cdc_req_ack_tx #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(10)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .i_data(din[0]),
        .o_ready(rdy[0]), .o_req(req[0]), .o_data(dout[0]), .i_ack(ack[0]),
        .o_done(done[0]), .o_busy(busy[0]), .o_err(err[0]), .i_err_clr(clr[0])
    );

    cdc_req_ack_tx #(.DATA_W(8), .SYNC_STAGES(3), .TIMEOUT(10)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .i_data(din[1]),
        .o_ready(rdy[1]), .o_req(req[1]), .o_data(dout[1]), .i_ack(ack[1]),
        .o_done(done[1]), .o_busy(busy[1]), .o_err(err[1]), .i_err_clr(clr[1])
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        int         acc;
        int         lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input int k, input logic [7:0] d, input int acc, input int lat);
        exp_t e;
        e.data = d;
        e.acc  = acc;
        e.lat  = lat;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic sb_pop(input int k);
        exp_t e;
        int   sz;
        sz = (k == 0) ? q0.size() : q1.size();
        n_chk++;
        if (sz == 0) begin
            n_err++;
            $display("FAIL dut%0d_spurious_done: o_done=1 with nothing outstanding, expected 0 (cycle %0d)", k, cyc);
        end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("dut%0d_done_data", k), 32'(dout[k]), 32'(e.data));
            chk($sformatf("dut%0d_xfer_len", k), 32'(cyc - e.acc + 1), 32'(e.lat));
        end
    endtask

    // Monitor: scoreboard on o_done, and o_data stability while o_req stays high.
    initial begin
        logic       prev_req [2];
        logic [7:0] held     [2];
        prev_req = '{1'b0, 1'b0};
        held     = '{8'h00, 8'h00};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_n === 1'b1) begin
                    if (done[k] === 1'b1) sb_pop(k);
                    if (prev_req[k] === 1'b1 && req[k] === 1'b1)
                        chk($sformatf("dut%0d_data_stable", k), 32'(dout[k]), 32'(held[k]));
                end
                prev_req[k] = req[k];
                held[k]     = dout[k];
            end
        end
    end

    // Destination model: raises ack up_dly negedges after seeing o_req high,
    // drops it dn_dly negedges after seeing o_req low.
    initial begin
        int cnt [2];
        cnt      = '{0, 0};
        ack_auto = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (auto_on[k] !== 1'b1) begin
                    cnt[k]      = 0;
                    ack_auto[k] = 1'b0;
                end else if (req[k] === 1'b1 && !ack_auto[k]) begin
                    if (cnt[k] >= up_dly[k]) begin ack_auto[k] = 1'b1; cnt[k] = 0; end
                    else cnt[k]++;
                end else if (req[k] === 1'b0 && ack_auto[k]) begin
                    if (cnt[k] >= dn_dly[k]) begin ack_auto[k] = 1'b0; cnt[k] = 0; end
                    else cnt[k]++;
                end else begin
                    cnt[k] = 0;
                end
            end
        end
    end

    // Present a word and wait for it to be taken; returns at the negedge
    // following the accept edge.
    task automatic issue(input int k, input logic [7:0] d, input int lat, input bit hold_valid);
        bit ok;
        ok     = 1'b0;
        vld[k] = 1'b1;
        din[k] = d;
        for (int i = 0; i < 100; i++) begin
            if (rdy[k] === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk($sformatf("dut%0d_accept_wait", k), 32'(ok), 32'd1);
        if (ok) sb_push(k, d, cyc + 1, lat);
        @(negedge clk);
        if (!hold_valid) vld[k] = 1'b0;
    endtask

    task automatic wait_req(input int k, input logic v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req[k] === v) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk($sformatf("dut%0d_req_wait_%0d", k, v), 32'(ok), 32'd1);
    endtask

    task automatic drain(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (((k == 0) ? q0.size() : q1.size()) == 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk($sformatf("dut%0d_drain", k), 32'(ok), 32'd1);
    endtask

    initial begin
        int  e_cyc;
        bit  ok;
        logic [7:0] words [3];

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; din[k] = 8'h00; clr[k] = 1'b0; ack_man[k] = 1'b0;
            auto_on[k] = 1'b0; up_dly[k] = 0; dn_dly[k] = 0;
        end

        // Reset: outputs while held in reset and right after release.
        @(negedge clk);
        chk("rst_during_ready", 32'(rdy[0]), 32'd1);
        chk("rst_during_busy",  32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_busy",  32'(busy[0]), 32'd0);
        chk("rst_req",   32'(req[0]), 32'd0);
        chk("rst_data",  32'(dout[0]), 32'd0);
        chk("rst_done",  32'(done[0]), 32'd0);
        chk("rst_err",   32'(err[0]), 32'd0);
        chk("rst3_ready", 32'(rdy[1]), 32'd1);
        chk("rst3_req",   32'(req[1]), 32'd0);

        // Test 1: single transfer, ack 3 cycles after each req edge.
        auto_on[0] = 1'b1; up_dly[0] = 2; dn_dly[0] = 2;
        issue(0, 8'hA5, 11, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done[0] === 1'b1) begin ok = 1'b1; break; end
            chk("t1_busy_mid", 32'(busy[0]), 32'd1);
            @(negedge clk);
        end
        chk("t1_done_seen", 32'(ok), 32'd1);
        chk("t1_busy_at_done", 32'(busy[0]), 32'd0);
        drain(0);

        // Test 2: back-to-back words with i_valid held, instant acknowledge.
        up_dly[0] = 0; dn_dly[0] = 0;
        words = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) issue(0, words[i], 7, (i < 2));
        vld[0] = 1'b0;
        drain(0);

        // Test 3: stale acknowledge blocks accepts until it has been released.
        auto_on[0] = 1'b0;
        ack_man[0] = 1'b1;
        repeat (3) @(negedge clk);
        vld[0] = 1'b1; din[0] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            chk("t3_stale_ready", 32'(rdy[0]), 32'd0);
            chk("t3_stale_req",   32'(req[0]), 32'd0);
            @(negedge clk);
        end
        ack_man[0] = 1'b0;
        e_cyc = cyc;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req[0] === 1'b1) begin ok = 1'b1; break; end
        end
        chk("t3_req_rise", 32'(ok), 32'd1);
        chk("t3_accept_edge", 32'(cyc - e_cyc), 32'd3);
        sb_push(0, 8'h5A, cyc, 7);
        vld[0] = 1'b0;
        ack_man[0] = 1'b1;
        wait_req(0, 1'b0);
        ack_man[0] = 1'b0;
        drain(0);

        // Test 4: timeout after 10 REQ cycles, late ack still completes.
        issue(0, 8'h3C, 22, 1'b0);
        repeat (9) @(negedge clk);
        chk("t4_err_before", 32'(err[0]), 32'd0);
        @(negedge clk);
        chk("t4_err_set", 32'(err[0]), 32'd1);
        chk("t4_req_held", 32'(req[0]), 32'd1);
        repeat (5) @(negedge clk);
        chk("t4_req_still", 32'(req[0]), 32'd1);
        chk("t4_err_sticky", 32'(err[0]), 32'd1);
        ack_man[0] = 1'b1;
        wait_req(0, 1'b0);
        ack_man[0] = 1'b0;
        drain(0);
        chk("t4_err_after_done", 32'(err[0]), 32'd1);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("t4_err_cleared", 32'(err[0]), 32'd0);

        // Test 5: reset while in REL.
        auto_on[0] = 1'b1; up_dly[0] = 0; dn_dly[0] = 20;
        issue(0, 8'hE7, 0, 1'b0);
        wait_req(0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_req",   32'(req[0]), 32'd0);
        chk("t5_data",  32'(dout[0]), 32'd0);
        chk("t5_busy",  32'(busy[0]), 32'd0);
        chk("t5_done",  32'(done[0]), 32'd0);
        chk("t5_err",   32'(err[0]), 32'd0);
        chk("t5_ready", 32'(rdy[0]), 32'd1);
        repeat (25) @(negedge clk);
        up_dly[0] = 0; dn_dly[0] = 0;

        // Test 6: SYNC_STAGES=3 instance, minimum and delayed round trips.
        auto_on[1] = 1'b1; up_dly[1] = 0; dn_dly[1] = 0;
        issue(1, 8'hC3, 9, 1'b0);
        drain(1);
        up_dly[1] = 2; dn_dly[1] = 2;
        issue(1, 8'h96, 13, 1'b0);
        drain(1);

        repeat (5) @(negedge clk);
        chk("end_q0_empty", 32'(q0.size()), 32'd0);
        chk("end_q1_empty", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cdc_req_ack_tx.md
# cdc_req_ack_tx

Source-side controller for a 4-phase req/ack clock-domain-crossing handshake. It captures a data word from a local valid/ready producer and holds it stable on `o_data` while driving `o_req` across to the destination domain. It synchronizes the returning asynchronous acknowledge through a multi-flop synchronizer chain and sequences the full req-up / ack-up / req-down / ack-down protocol. It sits in the source clock domain, paired with a destination-side receiver that registers `o_data` once its synchronized copy of `o_req` rises.

## Interface
Parameters:
- `DATA_W`, default 8: width of the transferred word.
- `SYNC_STAGES`, default 2: number of flops in the `i_ack` synchronizer chain. Legal range is 2 to 4.
- `TIMEOUT`, default 255: cycles a wait state may last before the error flag sets. A value of 0 disables the timeout.

Ports (all logic is in one clock domain; reset is synchronous and active-low):
- `i_clk`, in, 1: source-domain clock.
- `i_rst_n`, in, 1: synchronous active-low reset, sampled on the rising edge of `i_clk`.
- `i_valid`, in, 1: producer has a word on `i_data`.
- `i_data`, in, DATA_W: word to transfer.
- `o_ready`, out, 1: controller accepts a word this cycle.
- `o_req`, out, 1: request to the destination domain, registered.
- `o_data`, out, DATA_W: captured word, registered. Stable for as long as `o_req` is high.
- `i_ack`, in, 1: acknowledge from the destination domain. Asynchronous to `i_clk`.
- `o_done`, out, 1: one-cycle pulse marking completion of a transfer.
- `o_busy`, out, 1: a transfer is in progress.
- `o_err`, out, 1: sticky timeout flag.
- `i_err_clr`, in, 1: clears `o_err`.

## Operation
- `ack_s` is the output of the last flop of a SYNC_STAGES-deep synchronizer on `i_ack`. The FSM uses only `ack_s`, never `i_ack` directly.
- FSM states: IDLE, REQ, REL.
  - IDLE: `o_ready` = !`ack_s`. On `i_valid` && `o_ready`:
    - `o_data` <= `i_data`;
    - `o_req` <= 1;
    - go to REQ.
  - IDLE while `ack_s` = 1 (a stale acknowledge): accept nothing and stay in IDLE.
  - REQ: `o_req` = 1. On `ack_s` = 1: `o_req` <= 0 and go to REL.
  - REL: `o_req` = 0. On `ack_s` = 0: go to IDLE and set `o_done` <= 1 for one cycle.
- `o_busy` = (state != IDLE). `o_ready` = 0 whenever `o_busy` = 1. Both are combinational from the state and `ack_s`.
- `o_data` changes only on an accept. It holds its value through REQ and REL and after the return to IDLE.
- `i_valid` and `i_data` are ignored outside IDLE. No input buffering exists, so the producer must hold its word until `o_ready` is high.
- Timeout:
  - A wait counter clears on every state transition and increments each cycle spent in REQ or REL.
  - The counter saturates at TIMEOUT.
  - When it reaches TIMEOUT (with TIMEOUT != 0), `o_err` <= 1.
  - The FSM does not abort. It keeps waiting, because abandoning a 4-phase handshake midway corrupts the protocol.
- `i_err_clr` = 1 sets `o_err` <= 0. If a set and a clear occur in the same cycle, the set wins.
- Reset (`i_rst_n` = 0 at a clock edge), from any state, including mid-transfer:
  - state <= IDLE;
  - `o_req`, `o_data`, `o_done`, `o_err`, the wait counter and all synchronizer flops <= 0.
- Outputs during and immediately after reset: `o_ready` = 1, `o_busy` = 0.
- The destination side must tolerate `o_req` dropping because of a reset.

## Timing
- Accept at edge N: `o_req` = 1 and `o_data` is valid from N+1.
- `i_ack` rises before edge M: `ack_s` = 1 from edge M+SYNC_STAGES-1 onward. `o_req` falls one edge after that.
- Minimum transfer time, counted from accept to `o_done`, is 2 × SYNC_STAGES + 3 cycles when the destination responds instantly. This follows from the sequencing above.
- `o_done` is high in the first IDLE cycle. `o_ready` may be high in that same cycle, so back-to-back accepts are allowed when `ack_s` = 0.
- Throughput is at most one word per complete 4-phase round trip.

## Test plan
1. Single transfer, SYNC_STAGES = 2.
   - Stimulus: `i_data` = 8'hA5 with `i_valid` for one cycle. A bench model raises `i_ack` 3 cycles after `o_req` rises and drops it 3 cycles after `o_req` falls.
   - Required: `o_data` = 8'hA5 throughout; `o_req` sequence 0→1→0; exactly one `o_done` pulse; `o_busy` high from accept until `o_done`.
2. Back-to-back transfers.
   - Stimulus: `i_valid` held high with `i_data` = 8'h01, then 8'h02, then 8'h03.
   - Required: three accepts, each only when `o_ready` = 1; `o_data` sequence 01, 02, 03; three `o_done` pulses; `o_data` never changes while `o_req` = 1.
3. Stale acknowledge.
   - Stimulus: hold `i_ack` = 1 after reset with `i_valid` = 1.
   - Required: `o_ready` = 0 and `o_req` stays 0. After `i_ack` drops, the accept occurs SYNC_STAGES cycles later.
4. Timeout, TIMEOUT = 10.
   - Stimulus: accept a word and never raise `i_ack`.
   - Required: `o_err` = 1 after 10 cycles in REQ and `o_req` stays 1. A later `i_ack` completes the transfer normally. Pulsing `i_err_clr` clears `o_err`.
5. Reset mid-operation.
   - Stimulus: assert `i_rst_n` = 0 for 1 cycle while in REL.
   - Required: the next cycle shows `o_req` = 0, `o_data` = 0, `o_busy` = 0, `o_done` = 0, `o_err` = 0, with no spurious `o_done` pulse.
6. Synchronizer depth.
   - Stimulus: repeat test 1 with SYNC_STAGES = 3.
   - Required: each ack-to-response step is one cycle longer than in test 1; the minimum transfer time is 2 × 3 + 3 = 9 cycles.
